// File: rtl/victim_write_buffer.sv
// Single-entry victim write buffer between the L1 data cache and the memory arbiter.
// Holds one evicted dirty line, drains it when idle and serves reads that hit it.
module victim_write_buffer (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  c_address_i,
    input  logic [255:0] c_line_i,
    input  logic         c_read_i,
    input  logic         c_write_i,
    output logic [255:0] c_line_o,
    output logic         c_resp_o,
    output logic [31:0]  a_address_o,
    output logic [255:0] a_line_o,
    output logic         a_read_o,
    output logic         a_write_o,
    input  logic [255:0] a_line_i,
    input  logic         a_resp_i,
    output logic         empty_o
);

    typedef enum logic [2:0] {
        StIdle,
        StWbAck,
        StHitAck,
        StRdMem,
        StRdAck,
        StDrain
    } state_e;

    state_e        state_q, state_d;
    logic          buf_valid_q, buf_valid_d;
    logic [26:0]   buf_tag_q, buf_tag_d;
    logic [255:0]  buf_line_q, buf_line_d;
    logic [255:0]  ret_line_q, ret_line_d;
    logic          resp_q, resp_d;
    logic          hit;

    assign hit = buf_valid_q && (c_address_i[31:5] == buf_tag_q);

    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_line_d  = buf_line_q;
        ret_line_d  = ret_line_q;
        a_read_o    = 1'b0;
        a_write_o   = 1'b0;
        a_address_o = 32'h0;

        case (state_q)
            StIdle: begin
                // Write wins over read; a missing write waits behind a drain.
                if (c_write_i) begin
                    if (!buf_valid_q || hit) begin
                        buf_valid_d = 1'b1;
                        buf_tag_d   = c_address_i[31:5];
                        buf_line_d  = c_line_i;
                        state_d     = StWbAck;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (c_read_i) begin
                    if (hit) begin
                        ret_line_d = buf_line_q;
                        state_d    = StHitAck;
                    end else begin
                        state_d = StRdMem;
                    end
                end else if (buf_valid_q) begin
                    state_d = StDrain;
                end
            end
            StWbAck, StHitAck, StRdAck: state_d = StIdle;
            StRdMem: begin
                a_read_o    = 1'b1;
                a_address_o = {c_address_i[31:5], 5'b0};
                if (a_resp_i) begin
                    ret_line_d = a_line_i;
                    state_d    = StRdAck;
                end
            end
            StDrain: begin
                a_write_o   = 1'b1;
                a_address_o = {buf_tag_q, 5'b0};
                if (a_resp_i) begin
                    buf_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        resp_d = (state_d == StWbAck) || (state_d == StHitAck) || (state_d == StRdAck);
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q     <= StIdle;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= 27'h0;
            buf_line_q  <= 256'h0;
            ret_line_q  <= 256'h0;
            resp_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_line_q  <= buf_line_d;
            ret_line_q  <= ret_line_d;
            resp_q      <= resp_d;
        end
    end

    assign c_line_o = ret_line_q;
    assign c_resp_o = resp_q;
    assign a_line_o = buf_line_q;
    assign empty_o  = !buf_valid_q;

endmodule

// File: tb/tb_victim_write_buffer.sv
// Bench for victim_write_buffer: acts as cache and arbiter, checks against a
// memory-plus-buffer model of what the cache should observe.
module tb_victim_write_buffer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [31:0]  c_address_i;
    logic [255:0] c_line_i;
    logic         c_read_i;
    logic         c_write_i;
    logic [255:0] c_line_o;
    logic         c_resp_o;
    logic [31:0]  a_address_o;
    logic [255:0] a_line_o;
    logic         a_read_o;
    logic         a_write_o;
    logic [255:0] a_line_i;
    logic         a_resp_i;
    logic         empty_o;

    victim_write_buffer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .c_address_i (c_address_i),
        .c_line_i    (c_line_i),
        .c_read_i    (c_read_i),
        .c_write_i   (c_write_i),
        .c_line_o    (c_line_o),
        .c_resp_o    (c_resp_o),
        .a_address_o (a_address_o),
        .a_line_o    (a_line_o),
        .a_read_o    (a_read_o),
        .a_write_o   (a_write_o),
        .a_line_i    (a_line_i),
        .a_resp_i    (a_resp_i),
        .empty_o     (empty_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: main memory plus the one dirty line the buffer should be holding.
    logic [255:0] mem [logic [26:0]];
    bit           mvalid = 1'b0;
    logic [26:0]  mtag = '0;
    logic [255:0] mline = '0;

    // Arbiter behaviour and bookkeeping.
    int          fixed_delay = -1;
    bit          arb_pend = 1'b0;
    int          arb_cnt = 0;
    logic [31:0] arb_addr = '0;
    logic        arb_is_wr = 1'b0;
    int          last_rd_resp = -100;
    int          last_wr_resp = -100;
    int          n_rd = 0;
    int          n_wr = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mem_rd(input logic [26:0] t);
        logic [255:0] v;
        if (mem.exists(t)) return mem[t];
        for (int j = 0; j < 8; j++) v[j*32 +: 32] = {5'(j), t} ^ 32'h5A5A_0F0F;
        return v;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    always begin
        @(posedge clk);
        #2;
        a_resp_i = 1'b0;
        if (reset_n) begin
            arb_pend = 1'b0;
        end else if (a_read_o || a_write_o) begin
            chk("arb_exclusive", 256'(a_read_o & a_write_o), 256'(0));
            if (!arb_pend) begin
                arb_pend  = 1'b1;
                arb_cnt   = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                arb_addr  = a_address_o;
                arb_is_wr = a_write_o;
            end else begin
                chk("arb_addr_stable", 256'(a_address_o), 256'(arb_addr));
                chk("arb_kind_stable", 256'(a_write_o), 256'(arb_is_wr));
            end
            if (arb_cnt == 0) begin
                arb_pend = 1'b0;
                a_resp_i = 1'b1;
                if (a_write_o) begin
                    chk("drain_valid", 256'(mvalid), 256'(1));
                    chk("drain_addr", 256'(a_address_o), 256'({mtag, 5'b0}));
                    chk("drain_line", a_line_o, mline);
                    mem[a_address_o[31:5]] = a_line_o;
                    mvalid = 1'b0;
                    n_wr++;
                    last_wr_resp = cyc;
                end else begin
                    chk("rd_addr_aligned", 256'(a_address_o[4:0]), 256'(0));
                    a_line_i = mem_rd(a_address_o[31:5]);
                    n_rd++;
                    last_rd_resp = cyc;
                end
            end else begin
                arb_cnt--;
            end
        end else begin
            arb_pend = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output int rc);
        rc = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (c_resp_o) begin
                rc = cyc;
                break;
            end
        end
        n_cmp++;
        assert (rc >= 0) else begin
            n_bad++;
            $error("FAIL resp_timeout: observed no c_resp_o expected c_resp_o within 300 cycles");
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line);
        bit fast;
        int rc;
        int k;
        fast = !a_write_o && (!mvalid || mtag == addr[31:5]);
        c_write_i   = 1'b1;
        c_address_i = addr;
        c_line_i    = line;
        k = cyc;
        wait_resp(rc);
        chk("wr_latency", 256'(rc), 256'(fast ? k + 1 : last_wr_resp + 2));
        mvalid = 1'b1;
        mtag   = addr[31:5];
        mline  = line;
        tick();
        c_write_i   = 1'b0;
        c_address_i = $urandom;
        c_line_i    = rand_line();
    endtask

    task automatic do_read(input logic [31:0] addr);
        bit hit;
        int rc;
        int k;
        int rd0;
        logic [255:0] exp_line;
        hit = !a_write_o && mvalid && mtag == addr[31:5];
        rd0 = n_rd;
        c_read_i    = 1'b1;
        c_address_i = addr;
        k = cyc;
        wait_resp(rc);
        exp_line = (mvalid && mtag == addr[31:5]) ? mline : mem_rd(addr[31:5]);
        if (hit) begin
            chk("rd_hit_latency", 256'(rc), 256'(k + 1));
            chk("rd_hit_no_mem", 256'(n_rd), 256'(rd0));
        end else begin
            chk("rd_miss_latency", 256'(rc), 256'(last_rd_resp + 1));
            chk("rd_miss_one_mem", 256'(n_rd), 256'(rd0 + 1));
        end
        chk("rd_data", c_line_o, exp_line);
        tick();
        c_read_i    = 1'b0;
        c_address_i = $urandom;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] la, lb, lc, ld, le, lf;
        logic [31:0]  ra;
        int           op;
        int           wr0;
        int           rc;
        la = rand_line(); lb = rand_line(); lc = rand_line();
        ld = rand_line(); le = rand_line(); lf = rand_line();
        reset_n = 1'b1;
        c_address_i = '0; c_line_i = '0; c_read_i = 1'b0; c_write_i = 1'b0;
        a_line_i = '0; a_resp_i = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_c_resp", 256'(c_resp_o), 256'(0));
        chk("rst_c_line", c_line_o, 256'(0));
        chk("rst_a_read", 256'(a_read_o), 256'(0));
        chk("rst_a_write", 256'(a_write_o), 256'(0));
        chk("rst_a_addr", 256'(a_address_o), 256'(0));
        chk("rst_a_line", a_line_o, 256'(0));
        chk("rst_empty", 256'(empty_o), 256'(1));
        tick();
        reset_n = 1'b0;
        tick();

        // Write then read to a different line: read goes first, drain follows.
        fixed_delay = 2;
        do_write(32'h0000_1000, la);
        chk("full_after_wr", 256'(empty_o), 256'(0));
        do_read(32'h0000_2000);
        wr0 = n_wr;
        repeat (8) tick();
        chk("drain_count_1", 256'(n_wr), 256'(wr0 + 1));
        @(negedge clk);
        chk("empty_after_drain", 256'(empty_o), 256'(1));
        chk("idle_a_addr", 256'(a_address_o), 256'(0));
        chk("idle_a_line", a_line_o, la);
        tick();

        // Read hit on the buffered line.
        do_write(32'h0000_1000, la);
        do_read(32'h0000_101C);
        repeat (8) tick();

        // Coalescing write: one drain carrying the newer data.
        do_write(32'h0000_1000, la);
        wr0 = n_wr;
        do_write(32'h0000_1000, lb);
        repeat (10) tick();
        chk("coalesce_one_drain", 256'(n_wr), 256'(wr0 + 1));
        chk("coalesce_mem", mem[27'h80], lb);

        // Write miss with full buffer: drain old first.
        do_write(32'h0000_1000, la);
        do_write(32'h0000_3000, lc);
        chk("full_miss_old_drained", mem[27'h80], la);
        repeat (10) tick();
        chk("full_miss_new_drained", mem[27'h180], lc);

        // Arbiter stall; a read issued mid-drain waits for the drain.
        fixed_delay = 10;
        do_write(32'h0000_4000, ld);
        repeat (2) tick();
        chk("stall_draining", 256'(a_write_o), 256'(1));
        do_read(32'h0000_4000);
        chk("rd_after_drain", 256'(last_rd_resp > last_wr_resp), 256'(1));

        // Asynchronous reset while a memory read is outstanding.
        fixed_delay = 20;
        do_write(32'h0000_5000, le);
        c_read_i = 1'b1;
        c_address_i = 32'h0000_6000;
        tick();
        tick();
        chk("rdmem_active", 256'(a_read_o), 256'(1));
        #2;
        reset_n = 1'b1;
        #1;
        chk("rst_mid_a_read", 256'(a_read_o), 256'(0));
        chk("rst_mid_empty", 256'(empty_o), 256'(1));
        chk("rst_mid_c_resp", 256'(c_resp_o), 256'(0));
        mvalid = 1'b0;
        c_read_i = 1'b0;
        tick();
        reset_n = 1'b0;
        fixed_delay = -1;
        tick();
        do_write(32'h0000_7000, lf);
        chk("post_rst_full", 256'(empty_o), 256'(0));

        // Randomized traffic over a small set of lines.
        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 2));
            ra = 32'h0000_8000 | (32'($urandom_range(0, 3)) << 5) | 32'($urandom_range(0, 31));
            if (op == 0) do_write(ra, rand_line());
            else if (op == 1) do_read(ra);
            else repeat ($urandom_range(1, 5)) tick();
        end

        repeat (12) tick();
        @(negedge clk);
        chk("final_empty", 256'(empty_o), 256'(!mvalid));
        rc = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
